usr_sequencer: RTL and testbench

- Command-driven controller that sequences the universal shift register (USR) datapath in the TinyTapeout user project.
- Accepts load/shift commands over a valid/ready handshake.
- Drives the USR mode select and parallel-load data for the correct number of cycles.
- Reports progress (busy, shifts_left) and completion (done pulse); sits between the ui_in/uio_in decode and the USR core.

---
 rtl/usr_sequencer_if.sv | 42 ++++
 rtl/usr_sequencer.sv | 171 +++++++++++++++++
 tb/tb_usr_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usr_sequencer_if.sv
// -----------------------------------------------------------------------------
// usr_sequencer_if
// Purpose : Bundles the command handshake and the USR-facing outputs of the
//           USR sequencer. The sequencer connects through the slave modport;
//           the command source / USR side connects through the master modport.
// Signals :
//   cmd_valid   command present (source -> sequencer)
//   cmd_ready   sequencer can accept a command (sequencer -> source)
//   cmd_op      00 LOAD, 01 SHR, 10 SHL, 11 LOAD_SHR
//   cmd_count   number of shift cycles (ignored for LOAD)
//   cmd_data    parallel-load value
//   usr_mode    to USR: 00 HOLD, 01 shift right, 10 shift left, 11 load
//   usr_pdata   registered parallel-load data to USR
//   busy        command in progress
//   done        one-cycle completion pulse
//   shifts_left remaining shift cycles
// -----------------------------------------------------------------------------
interface usr_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic [1:0]       usr_mode;
  logic [WIDTH-1:0] usr_pdata;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] shifts_left;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data,
    input  cmd_ready, usr_mode, usr_pdata, busy, done, shifts_left
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data,
    output cmd_ready, usr_mode, usr_pdata, busy, done, shifts_left
  );
endinterface

// File: rtl/usr_sequencer.sv
// -----------------------------------------------------------------------------
// usr_sequencer
// Purpose : Command-driven controller that sequences the universal shift
//           register datapath. Accepts LOAD / SHR / SHL / LOAD_SHR commands
//           over a valid/ready handshake, drives the USR mode select and the
//           parallel-load data for the right number of cycles, and reports
//           progress (busy, shifts_left) and completion (done pulse).
// Ports   :
//   clk    system clock, rising edge
//   rst_n  synchronous, active-low reset
//   ena    design enable; low freezes the sequencer
//   bus    usr_sequencer_if.slave (command handshake + USR outputs)
//
// State table
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for a command, cmd_ready high when enabled
//   ST_LOAD  | one cycle of parallel load (usr_mode=11)
//   ST_SHIFT | shifting, one cycle per remaining count (usr_mode=01/10)
//   ST_DONE  | one-cycle done pulse, then back to idle
// -----------------------------------------------------------------------------
module usr_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  usr_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_SHR      = 2'b01;
  localparam logic [1:0] OP_SHL      = 2'b10;
  localparam logic [1:0] OP_LOAD_SHR = 2'b11;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             dir_left_q, dir_left_d;
  logic [CNT_W-1:0] shifts_left_q, shifts_left_d;
  logic [WIDTH-1:0] usr_pdata_q, usr_pdata_d;
  logic [1:0]       usr_mode_q, usr_mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cmd_fire;
  logic [CNT_W-1:0] cnt_clamped;

  assign bus.cmd_ready = (state_q == ST_IDLE) & ena & rst_n;
  assign cmd_fire      = bus.cmd_valid & bus.cmd_ready;

  // More shifts than the register is wide would only shift in zeros.
  assign cnt_clamped = (bus.cmd_count > CNT_MAX) ? CNT_MAX : bus.cmd_count;

  always_comb begin
    state_d       = state_q;
    dir_left_d    = dir_left_q;
    shifts_left_d = shifts_left_q;
    usr_pdata_d   = usr_pdata_q;

    // With ena low every register simply holds, which is the freeze.
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            usr_pdata_d = bus.cmd_data;
            dir_left_d  = (bus.cmd_op == OP_SHL);
            case (bus.cmd_op)
              OP_LOAD: begin
                shifts_left_d = '0;
                state_d       = ST_LOAD;
              end
              OP_LOAD_SHR: begin
                shifts_left_d = cnt_clamped;
                state_d       = ST_LOAD;
              end
              default: begin
                shifts_left_d = cnt_clamped;
                state_d       = (cnt_clamped == '0) ? ST_DONE : ST_SHIFT;
              end
            endcase
          end
        end
        ST_LOAD: begin
          // Only LOAD_SHR can carry a nonzero count into this state.
          state_d = (shifts_left_q != '0) ? ST_SHIFT : ST_DONE;
        end
        ST_SHIFT: begin
          if (shifts_left_q <= CNT_ONE) begin
            shifts_left_d = '0;
            state_d       = ST_DONE;
          end else begin
            shifts_left_d = shifts_left_q - CNT_ONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Output registers carry the decode of the state being entered, so the
    // outputs in any cycle come straight from flops.
    usr_mode_d = MODE_HOLD;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      ST_LOAD: begin
        usr_mode_d = MODE_LOAD;
        busy_d     = 1'b1;
      end
      ST_SHIFT: begin
        usr_mode_d = dir_left_d ? MODE_SHL : MODE_SHR;
        busy_d     = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        usr_mode_d = MODE_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      dir_left_q    <= 1'b0;
      shifts_left_q <= '0;
      usr_pdata_q   <= '0;
      usr_mode_q    <= MODE_HOLD;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_left_q    <= dir_left_d;
      shifts_left_q <= shifts_left_d;
      usr_pdata_q   <= usr_pdata_d;
      usr_mode_q    <= usr_mode_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // A frozen cycle must never present an active mode or a done pulse to the
  // USR; the held registers replay them once ena returns, so nothing is lost
  // or duplicated.
  assign bus.usr_mode    = ena ? usr_mode_q : MODE_HOLD;
  assign bus.done        = done_q & ena;
  assign bus.busy        = busy_q;
  assign bus.shifts_left = shifts_left_q;
  assign bus.usr_pdata   = usr_pdata_q;

endmodule

// File: tb/tb_usr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_usr_sequencer
// Purpose : Self-checking bench for usr_sequencer. Expected per-cycle traces
//           are built from the command rules (load cycle, N shift cycles,
//           done cycle), and a behavioural USR register driven by usr_mode is
//           compared with the arithmetic result of each command.
// -----------------------------------------------------------------------------
module tb_usr_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef struct {
    logic [1:0] mode;
    int         sl;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic rst_n;
  logic ena;

  int compared;
  int mismatched;
  int cmd_id;

  logic [WIDTH-1:0] usr_reg;
  logic [WIDTH-1:0] exp_reg;

  usr_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  usr_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural USR core: serial inputs are zero.
  always @(posedge clk) begin
    case (bus.usr_mode)
      2'b01:   usr_reg <= usr_reg >> 1;
      2'b10:   usr_reg <= usr_reg << 1;
      2'b11:   usr_reg <= bus.usr_pdata;
      default: usr_reg <= usr_reg;
    endcase
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command with ena held high and check every cycle until idle.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic [7:0] data);
    exp_t tr[$];
    int   n;
    int   guard;
    exp_t e;
    cmd_id++;
    n = (op == 2'b00) ? 0 : ((int'(cnt) > WIDTH) ? WIDTH : int'(cnt));
    if (op == 2'b00 || op == 2'b11) begin
      e.mode = 2'b11; e.sl = n; e.busy = 1'b1; e.done = 1'b0;
      tr.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      e.mode = (op == 2'b10) ? 2'b10 : 2'b01; e.sl = n - i; e.busy = 1'b1; e.done = 1'b0;
      tr.push_back(e);
    end
    e.mode = 2'b00; e.sl = 0; e.busy = 1'b0; e.done = 1'b1;
    tr.push_back(e);

    case (op)
      2'b00:   exp_reg = data;
      2'b01:   exp_reg = exp_reg >> n;
      2'b10:   exp_reg = exp_reg << n;
      default: exp_reg = data >> n;
    endcase

    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_count = cnt;
    bus.cmd_data  = data;
    #1;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    chk($sformatf("cmd%0d ready_before", cmd_id), {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    // Garbage on the command inputs must be ignored while busy.
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_count = 4'($urandom);
    bus.cmd_data  = ~data;
    for (int c = 0; c < tr.size(); c++) begin
      chk($sformatf("cmd%0d mode c%0d", cmd_id, c), {30'd0, bus.usr_mode}, {30'd0, tr[c].mode});
      chk($sformatf("cmd%0d shifts_left c%0d", cmd_id, c), {28'd0, bus.shifts_left}, tr[c].sl);
      chk($sformatf("cmd%0d busy c%0d", cmd_id, c), {31'd0, bus.busy}, {31'd0, tr[c].busy});
      chk($sformatf("cmd%0d done c%0d", cmd_id, c), {31'd0, bus.done}, {31'd0, tr[c].done});
      chk($sformatf("cmd%0d ready c%0d", cmd_id, c), {31'd0, bus.cmd_ready}, 32'd0);
      chk($sformatf("cmd%0d pdata c%0d", cmd_id, c), {24'd0, bus.usr_pdata}, {24'd0, data});
      tick();
    end
    chk($sformatf("cmd%0d ready_after", cmd_id), {31'd0, bus.cmd_ready}, 32'd1);
    chk($sformatf("cmd%0d done_after", cmd_id), {31'd0, bus.done}, 32'd0);
    chk($sformatf("cmd%0d usr_result", cmd_id), {24'd0, usr_reg}, {24'd0, exp_reg});
  endtask

  initial begin
    logic [7:0] shr_start;
    compared      = 0;
    mismatched    = 0;
    cmd_id        = 0;
    rst_n         = 1'b0;
    ena           = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_count = 4'd0;
    bus.cmd_data  = 8'hFF;
    exp_reg       = 8'h00;

    // Reset with a command pending.
    tick();
    tick();
    chk("rst usr_mode", {30'd0, bus.usr_mode}, 32'd0);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst shifts_left", {28'd0, bus.shifts_left}, 32'd0);
    chk("rst usr_pdata", {24'd0, bus.usr_pdata}, 32'd0);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();

    // Directed commands.
    run_cmd(2'b00, 4'd0, 8'hA5);
    run_cmd(2'b11, 4'd3, 8'h81);
    chk("load_shr final 10", {24'd0, usr_reg}, 32'h10);
    run_cmd(2'b10, 4'd0, 8'h5A);
    run_cmd(2'b00, 4'd0, 8'hFF);
    run_cmd(2'b01, 4'd15, 8'h00);
    chk("shr15 clamps to zero", {24'd0, usr_reg}, 32'h00);

    // ena dropped for 3 cycles with shifts_left=2, command held valid.
    run_cmd(2'b00, 4'd0, 8'hF0);
    shr_start     = exp_reg;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_count = 4'd5;
    bus.cmd_data  = 8'h11;
    #1;
    chk("ena ready_before", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ena pre sl%0d", i), {28'd0, bus.shifts_left}, 5 - i);
      chk($sformatf("ena pre mode%0d", i), {30'd0, bus.usr_mode}, 32'd1);
      tick();
    end
    ena           = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_count = 4'd0;
    bus.cmd_data  = 8'h3C;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ena frz mode%0d", i), {30'd0, bus.usr_mode}, 32'd0);
      chk($sformatf("ena frz sl%0d", i), {28'd0, bus.shifts_left}, 32'd2);
      chk($sformatf("ena frz busy%0d", i), {31'd0, bus.busy}, 32'd1);
      chk($sformatf("ena frz ready%0d", i), {31'd0, bus.cmd_ready}, 32'd0);
      chk($sformatf("ena frz done%0d", i), {31'd0, bus.done}, 32'd0);
      tick();
    end
    ena = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ena res mode%0d", i), {30'd0, bus.usr_mode}, 32'd1);
      chk($sformatf("ena res sl%0d", i), {28'd0, bus.shifts_left}, 2 - i);
      chk($sformatf("ena res ready%0d", i), {31'd0, bus.cmd_ready}, 32'd0);
      tick();
    end
    chk("ena done", {31'd0, bus.done}, 32'd1);
    chk("ena done ready", {31'd0, bus.cmd_ready}, 32'd0);
    exp_reg = shr_start >> 5;
    chk("ena usr_result", {24'd0, usr_reg}, {24'd0, exp_reg});
    tick();
    chk("ena idle ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("ena idle done", {31'd0, bus.done}, 32'd0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("ena held load mode", {30'd0, bus.usr_mode}, 32'd3);
    chk("ena held load pdata", {24'd0, bus.usr_pdata}, 32'h3C);
    tick();
    chk("ena held load done", {31'd0, bus.done}, 32'd1);
    tick();
    exp_reg = 8'h3C;
    chk("ena held load usr", {24'd0, usr_reg}, 32'h3C);

    // Reset mid-shift with shifts_left=4.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_count = 4'd6;
    bus.cmd_data  = 8'h77;
    #1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    chk("mid rst sl before", {28'd0, bus.shifts_left}, 32'd4);
    rst_n = 1'b0;
    tick();
    chk("mid rst mode", {30'd0, bus.usr_mode}, 32'd0);
    chk("mid rst sl", {28'd0, bus.shifts_left}, 32'd0);
    chk("mid rst busy", {31'd0, bus.busy}, 32'd0);
    chk("mid rst done", {31'd0, bus.done}, 32'd0);
    chk("mid rst ready", {31'd0, bus.cmd_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid rst ready rel", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    chk("mid rst no done", {31'd0, bus.done}, 32'd0);
    run_cmd(2'b00, 4'd0, 8'hC3);

    // Randomised commands against the trace model.
    for (int r = 0; r < 24; r++) begin
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
